systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 144 ++++++++++++++
 tb/tb_systolic_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Purpose  : Accepts one multi-lane operand beat per cycle for one dot-product
//            pass and feeds it into a systolic array. Lane i is delayed by
//            1+i register stages. Idle slots become zero-valued bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int IN_DIM = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES-1:0]          out_first,
  output logic                      busy,
  output logic                      done
);

  // The beat counter must be able to hold IN_DIM so that it never wraps in a pass.
  localparam int BCW = $clog2(IN_DIM + 1);
  localparam int DCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(IN_DIM - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(LANES - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  beat_q,  beat_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            done_q,  done_d;

  logic            accept;
  logic            first_beat;

  assign in_ready   = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign accept     = in_valid && (state_q == RUN);
  assign first_beat = (beat_q == '0);

  // Control state, counters and the done pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The drain counter holds the number of skew stages still
  // to empty; the pass ends on the edge where it decrements to zero, so done
  // lines up with the last word of the highest lane and a start presented in
  // that cycle is seen from IDLE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          beat_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          beat_d = beat_q + BCW'(1);
          if (beat_q == LAST_BEAT) begin
            if (LANES == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              drain_d = DRAIN_LOAD;
            end
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - DCW'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One skew pipeline per lane; lane i has 1+i stages carrying data and flags.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] data_q [0:i];
    logic [i:0]        valid_q;
    logic [i:0]        first_q;

    // Shift the lane pipeline; non-accept cycles enter as all-zero bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          data_q[j] <= '0;
        end
        valid_q <= '0;
        first_q <= '0;
      end else begin
        data_q[0]  <= accept ? in_data[i*DATA_W +: DATA_W] : '0;
        valid_q[0] <= accept;
        first_q[0] <= accept && first_beat;
        for (int j = 1; j <= i; j++) begin
          data_q[j]  <= data_q[j-1];
          valid_q[j] <= valid_q[j-1];
          first_q[j] <= first_q[j-1];
        end
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = data_q[i];
    assign out_valid[i]                 = valid_q[i];
    assign out_first[i]                 = first_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Purpose  : Directed, table-driven bench for systolic_feeder with
//            LANES=4, IN_DIM=3, DATA_W=32, plus a mid-pass reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int ID = 3;
  localparam int BW = LN * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [BW-1:0] out_data;
  logic [LN-1:0] out_valid;
  logic [LN-1:0] out_first;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_feeder #(
    .DATA_W (DW),
    .LANES  (LN),
    .IN_DIM (ID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_first (out_first),
    .busy      (busy),
    .done      (done)
  );

  // One cycle of stimulus and the outputs expected in that same cycle.
  typedef struct {
    logic          st;
    logic          iv;
    logic [BW-1:0] d;
    logic          rdy;
    logic          bsy;
    logic          dn;
    logic [LN-1:0] v;
    logic [LN-1:0] f;
    logic [BW-1:0] od;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic add(input logic st, input logic iv, input logic [BW-1:0] d,
                     input logic rdy, input logic bsy, input logic dn,
                     input logic [LN-1:0] v, input logic [LN-1:0] f,
                     input logic [BW-1:0] od);
    vec_t r;
    r.st = st; r.iv = iv; r.d = d; r.rdy = rdy; r.bsy = bsy; r.dn = dn;
    r.v = v; r.f = f; r.od = od;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_data"},  out_data,       '0);
    check({tag, " out_valid"}, BW'(out_valid), '0);
    check({tag, " out_first"}, BW'(out_first), '0);
    check({tag, " busy"},      BW'(busy),      '0);
    check({tag, " done"},      BW'(done),      '0);
    check({tag, " in_ready"},  BW'(in_ready),  '0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      @(posedge clk);
      #1;
      start    = vecs[k].st;
      in_valid = vecs[k].iv;
      in_data  = vecs[k].d;
      #1;
      check($sformatf("row%0d in_ready", k),  BW'(in_ready),  BW'(vecs[k].rdy));
      check($sformatf("row%0d busy", k),      BW'(busy),      BW'(vecs[k].bsy));
      check($sformatf("row%0d done", k),      BW'(done),      BW'(vecs[k].dn));
      check($sformatf("row%0d out_valid", k), BW'(out_valid), BW'(vecs[k].v));
      check($sformatf("row%0d out_first", k), BW'(out_first), BW'(vecs[k].f));
      check($sformatf("row%0d out_data", k),  out_data,       vecs[k].od);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] z;
    int            n_main;
    z = '0;

    // Basic pass: start at cycle 0, beats at cycles 1..3, done at cycle 7.
    add(1, 0, z,                 0, 0, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(1, 2, 3, 4),    1, 1, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(5, 6, 7, 8),    1, 1, 0, 4'b0001, 4'b0001, pk(1, 0, 0, 0));
    add(0, 1, pk(9, 10, 11, 12), 1, 1, 0, 4'b0011, 4'b0010, pk(5, 2, 0, 0));
    add(0, 1, pk(13, 14, 15, 16),0, 1, 0, 4'b0111, 4'b0100, pk(9, 6, 3, 0));
    add(0, 1, pk(13, 14, 15, 16),0, 1, 0, 4'b1110, 4'b1000, pk(0, 10, 7, 4));
    add(0, 0, z,                 0, 1, 0, 4'b1100, 4'b0000, pk(0, 0, 11, 8));
    add(0, 0, z,                 0, 0, 1, 4'b1000, 4'b0000, pk(0, 0, 0, 12));
    add(0, 0, z,                 0, 0, 0, 4'b0000, 4'b0000, z);
    // Bubble on pass cycle 2: one zero slot per lane, done one cycle later.
    add(1, 0, z,                 0, 0, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(1, 2, 3, 4),    1, 1, 0, 4'b0000, 4'b0000, z);
    add(0, 0, pk(99, 99, 99, 99),1, 1, 0, 4'b0001, 4'b0001, pk(1, 0, 0, 0));
    add(0, 1, pk(5, 6, 7, 8),    1, 1, 0, 4'b0010, 4'b0010, pk(0, 2, 0, 0));
    add(0, 1, pk(9, 10, 11, 12), 1, 1, 0, 4'b0101, 4'b0100, pk(5, 0, 3, 0));
    add(0, 0, z,                 0, 1, 0, 4'b1011, 4'b1000, pk(9, 6, 0, 4));
    add(0, 0, z,                 0, 1, 0, 4'b0110, 4'b0000, pk(0, 10, 7, 0));
    add(0, 0, z,                 0, 1, 0, 4'b1100, 4'b0000, pk(0, 0, 11, 8));
    // Done cycle with start: back-to-back pass; start pulses while busy ignored.
    add(1, 0, z,                 0, 0, 1, 4'b1000, 4'b0000, pk(0, 0, 0, 12));
    add(1, 1, pk(21, 22, 23, 24),1, 1, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(25, 26, 27, 28),1, 1, 0, 4'b0001, 4'b0001, pk(21, 0, 0, 0));
    add(0, 1, pk(29, 30, 31, 32),1, 1, 0, 4'b0011, 4'b0010, pk(25, 22, 0, 0));
    add(1, 0, z,                 0, 1, 0, 4'b0111, 4'b0100, pk(29, 26, 23, 0));
    add(1, 0, z,                 0, 1, 0, 4'b1110, 4'b1000, pk(0, 30, 27, 24));
    add(0, 0, z,                 0, 1, 0, 4'b1100, 4'b0000, pk(0, 0, 31, 28));
    add(0, 0, z,                 0, 0, 1, 4'b1000, 4'b0000, pk(0, 0, 0, 32));
    add(0, 0, z,                 0, 0, 0, 4'b0000, 4'b0000, z);
    // in_valid in IDLE without start: nothing accepted or emitted.
    add(0, 1, pk(77, 78, 79, 80),0, 0, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(77, 78, 79, 80),0, 0, 0, 4'b0000, 4'b0000, z);
    n_main = vecs.size();
    // Fresh pass after the mid-pass reset.
    add(1, 0, z,                    0, 0, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(101, 102, 103, 104),1, 1, 0, 4'b0000, 4'b0000, z);
    add(0, 1, pk(105, 106, 107, 108),1, 1, 0, 4'b0001, 4'b0001, pk(101, 0, 0, 0));
    add(0, 1, pk(109, 110, 111, 112),1, 1, 0, 4'b0011, 4'b0010, pk(105, 102, 0, 0));
    add(0, 0, z,                    0, 1, 0, 4'b0111, 4'b0100, pk(109, 106, 103, 0));
    add(0, 0, z,                    0, 1, 0, 4'b1110, 4'b1000, pk(0, 110, 107, 104));
    add(0, 0, z,                    0, 1, 0, 4'b1100, 4'b0000, pk(0, 0, 111, 108));
    add(0, 0, z,                    0, 0, 1, 4'b1000, 4'b0000, pk(0, 0, 0, 112));
    add(0, 0, z,                    0, 0, 0, 4'b0000, 4'b0000, z);

    // Reset state.
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    run_rows(0, n_main);

    // Reset asserted mid-RUN after one accepted beat.
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = pk(41, 42, 43, 44);
    @(posedge clk); #1;
    in_data = pk(45, 46, 47, 48);
    #1;
    check("midrst pre out_valid", BW'(out_valid), BW'(4'b0001));
    check("midrst pre out_data",  out_data,       pk(41, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst async");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_all_zero("midrst held");
    #2;
    rst_n = 1'b1;
    // No start after release: IDLE behaviour, no done from the aborted pass.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = pk(k + 60, k + 61, k + 62, k + 63);
      #1;
      check($sformatf("postrst%0d idle", k), {out_data, out_valid, busy, done, in_ready},
            '0);
    end
    in_valid = 1'b0;

    run_rows(n_main, vecs.size());

    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
